cp_zero: RTL and testbench

MIPS-style coprocessor 0 holding Status (reg 12), Cause (reg 13) and EPC (reg 14). It latches six hardware interrupt lines and an ALU trap, and raises the `exl` exception-level flag to the core. It captures the return address on exception entry. It sits beside the CPU datapath and is accessed through the mfc0/mtc0 read/write port.

---
 rtl/cp_zero_pkg.sv | 37 +++
 rtl/cp_zero.sv | 118 +++++++++++
 tb/tb_cp_zero.sv | 162 ++++++++++++++++
 3 files changed

// File: rtl/cp_zero_pkg.sv
// cp_zero_pkg: shared constants for the CP0 register block.
//   - CP0 register numbers for Status, Cause and EPC
//   - bit positions of the Status and Cause fields
//   - ExcCode values and the helper that picks the next ExcCode
package cp_zero_pkg;

    localparam logic [4:0] REG_STATUS = 5'd12;
    localparam logic [4:0] REG_CAUSE  = 5'd13;
    localparam logic [4:0] REG_EPC    = 5'd14;

    // Status fields
    localparam int ST_IE     = 0;
    localparam int ST_EXL    = 1;
    localparam int ST_IM_LSB = 8;
    // Hardware interrupt i is gated by Status bit i+10, i.e. IM[i+2]
    localparam int IM_INT_OFS = 2;

    // Cause fields
    localparam int CA_EXC_LSB = 2;
    localparam int CA_IP_LSB  = 10;
    localparam int CA_IV      = 23;

    typedef enum logic [4:0] {
        EXC_INT  = 5'd0,
        EXC_NONE = 5'd10,
        EXC_TRAP = 5'd12
    } exc_code_e;

    // Interrupts outrank the trap; with neither pending, report NONE.
    function automatic exc_code_e exc_select(input logic [5:0] ip_next,
                                             input logic       trap_next);
        if (ip_next != 6'd0) return EXC_INT;
        else if (trap_next)  return EXC_TRAP;
        else                 return EXC_NONE;
    endfunction

endpackage

// File: rtl/cp_zero.sv
// cp_zero: MIPS-style coprocessor 0 with Status (12), Cause (13), EPC (14).
// Ports:
//   clk        rising-edge clock
//   rst        asynchronous active-low reset
//   we1        write enable for register `addr`
//   alu_trap   ALU trap request (level)
//   addr[4:0]  CP0 register number for mfc0/mtc0
//   interrupt  six hardware interrupt lines
//   wd[31:0]   mtc0 write data
//   pcp4       PC+4 of the current instruction (EPC source)
//   exl        exception active (combinational)
//   iv         Cause.IV
//   rd1[31:0]  combinational read data for `addr`
module cp_zero
    import cp_zero_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        we1,
    input  logic        alu_trap,
    input  logic [4:0]  addr,
    input  logic [5:0]  interrupt,
    input  logic [31:0] wd,
    input  logic [31:0] pcp4,
    output logic        exl,
    output logic        iv,
    output logic [31:0] rd1
);

    logic [7:0]  im;
    logic        exl_reg;
    logic        ie;
    logic [5:0]  ip;
    logic        trap_flag;
    logic        trap_seen;
    exc_code_e   exc_code;
    logic        iv_reg;
    logic [31:0] epc;

    logic        wr_status, wr_cause, wr_epc;
    logic [5:0]  im_int, req, ip_rd, ip_next;
    logic        trap_pend, trap_flag_next, epc_capture;

    assign wr_status = we1 && (addr == REG_STATUS);
    assign wr_cause  = we1 && (addr == REG_CAUSE);
    assign wr_epc    = we1 && (addr == REG_EPC);

    assign im_int  = im[IM_INT_OFS +: 6];
    assign req     = interrupt & im_int & {6{ie}};
    assign ip_rd   = ip | req;
    // Masked with the pre-write IM, so clearing a mask bit drops IP one edge later.
    assign ip_next = ip_rd & im_int;

    // One trap per alu_trap pulse: trap_seen blocks re-arming until the line drops.
    assign trap_pend      = alu_trap & ~trap_seen;
    // A new trap beats a simultaneous IE=1 write that would clear the flag.
    assign trap_flag_next = trap_pend | (trap_flag & ~(wr_status & wd[ST_IE]));

    // EPC only latches on entry from the idle state, not while already handling.
    assign epc_capture = (ip == 6'd0) && !trap_flag && ((req != 6'd0) || trap_pend);

    assign exl = (|ip_rd) | trap_flag | trap_pend;
    assign iv  = iv_reg;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            im        <= '0;
            exl_reg   <= 1'b0;
            ie        <= 1'b0;
            ip        <= '0;
            trap_flag <= 1'b0;
            trap_seen <= 1'b0;
            exc_code  <= EXC_NONE;
            iv_reg    <= 1'b0;
            epc       <= '0;
        end else begin
            if (wr_status) begin
                im      <= wd[ST_IM_LSB +: 8];
                ie      <= wd[ST_IE];
                exl_reg <= wd[ST_EXL] & ~wd[ST_IE];
            end
            if (wr_cause)
                iv_reg <= wd[CA_IV];

            ip        <= ip_next;
            trap_flag <= trap_flag_next;
            if (trap_pend)
                trap_seen <= 1'b1;
            else if (!alu_trap)
                trap_seen <= 1'b0;
            exc_code  <= exc_select(ip_next, trap_flag_next);

            if (epc_capture)
                epc <= pcp4;
            else if (wr_epc)
                epc <= wd;
        end
    end

    always_comb begin
        rd1 = '0;
        case (addr)
            REG_STATUS: begin
                rd1[ST_IM_LSB +: 8] = im;
                rd1[ST_EXL]         = exl_reg | trap_flag | trap_pend;
                rd1[ST_IE]          = ie;
            end
            REG_CAUSE: begin
                rd1[CA_IV]             = iv_reg;
                rd1[CA_IP_LSB +: 6]    = ip_rd;
                rd1[CA_EXC_LSB +: 5]   = exc_code;
            end
            REG_EPC: rd1 = epc;
            default: rd1 = '0;
        endcase
    end

endmodule

// File: tb/tb_cp_zero.sv
// tb_cp_zero: table-driven check of cp_zero. Each vector drives inputs after
// the falling edge, compares rd1/exl/iv before the next rising edge, then the
// rising edge applies the vector. A hand-written sequence covers async reset
// in the middle of an exception.
module tb_cp_zero;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        we1 = 1'b0;
    logic        alu_trap = 1'b0;
    logic [4:0]  addr = '0;
    logic [5:0]  interrupt = '0;
    logic [31:0] wd = '0;
    logic [31:0] pcp4 = '0;
    logic        exl, iv;
    logic [31:0] rd1;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    cp_zero dut (
        .clk(clk), .rst(rst), .we1(we1), .alu_trap(alu_trap), .addr(addr),
        .interrupt(interrupt), .wd(wd), .pcp4(pcp4),
        .exl(exl), .iv(iv), .rd1(rd1)
    );

    typedef struct {
        logic        we;
        logic [4:0]  addr;
        logic [31:0] wd;
        logic        trap;
        logic [5:0]  intr;
        logic [31:0] pcp4;
        logic [31:0] exp_rd;
        logic        exp_exl;
        logic        exp_iv;
    } vec_t;

    vec_t vq[$];

    task automatic v(input logic we_i, input logic [4:0] a, input logic [31:0] d,
                     input logic t, input logic [5:0] in, input logic [31:0] pc,
                     input logic [31:0] er, input logic ee, input logic ei);
        vec_t x;
        x.we = we_i; x.addr = a; x.wd = d; x.trap = t; x.intr = in; x.pcp4 = pc;
        x.exp_rd = er; x.exp_exl = ee; x.exp_iv = ei;
        vq.push_back(x);
    endtask

    task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic chk1(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0b expected %0b", name, act, exp);
        end
    endtask

    initial begin
        // we addr wd trap intr pcp4 | rd1 exl iv   (outputs sampled before the edge)
        // reset state
        v(0, 12, 0, 0, 6'h00, 32'h0, 32'h0000_0000, 0, 0);          // 0
        v(0, 13, 0, 0, 6'h00, 32'h0, 32'h0000_0028, 0, 0);          // 1
        v(0, 14, 0, 0, 6'h00, 32'h0, 32'h0000_0000, 0, 0);          // 2
        // status write masking
        v(1, 12, 32'hFFF1, 0, 6'h00, 32'h0, 32'h0000_0000, 0, 0);   // 3
        v(0, 12, 0, 0, 6'h00, 32'h0, 32'h0000_FF01, 0, 0);          // 4
        // trap sequence, alu_trap held high
        v(0, 12, 0, 1, 6'h00, 32'h100, 32'h0000_FF03, 1, 0);        // 5
        v(0, 13, 0, 1, 6'h00, 32'h100, 32'h0000_0030, 1, 0);        // 6 ExcCode=12
        v(1, 12, 32'hFE02, 1, 6'h00, 32'h100, 32'h0000_FF03, 1, 0); // 7
        v(0, 12, 0, 1, 6'h00, 32'h100, 32'h0000_FE02, 1, 0);        // 8
        v(1, 12, 32'hFFFF, 1, 6'h00, 32'h100, 32'h0000_FE02, 1, 0); // 9
        v(0, 12, 0, 1, 6'h00, 32'h100, 32'h0000_FF01, 0, 0);        // 10
        v(0, 13, 0, 1, 6'h00, 32'h100, 32'h0000_0028, 0, 0);        // 11
        // cause is read-only except IV
        v(1, 13, 32'h0000_FAFF, 0, 6'h00, 32'h100, 32'h0000_0028, 0, 0); // 12
        v(0, 13, 0, 0, 6'h00, 32'h100, 32'h0000_0028, 0, 0);        // 13
        v(1, 13, 32'h0080_0000, 0, 6'h00, 32'h100, 32'h0000_0028, 0, 0); // 14
        v(0, 13, 0, 0, 6'h00, 32'h100, 32'h0080_0028, 0, 1);        // 15
        v(1, 13, 32'h0, 0, 6'h00, 32'h100, 32'h0080_0028, 0, 1);    // 16
        v(0, 13, 0, 0, 6'h00, 32'h100, 32'h0000_0028, 0, 0);        // 17
        // interrupt entry
        v(0, 13, 0, 0, 6'h21, 32'h1234_ABCD, 32'h0000_8428, 1, 0);  // 18
        v(0, 13, 0, 0, 6'h21, 32'h1234_ABCD, 32'h0000_8400, 1, 0);  // 19
        v(0, 13, 0, 0, 6'h00, 32'h1234_ABCD, 32'h0000_8400, 1, 0);  // 20
        v(0, 14, 0, 0, 6'h00, 32'hDEAD_BEEF, 32'h1234_ABCD, 1, 0);  // 21
        v(0, 14, 0, 0, 6'h00, 32'hDEAD_BEEF, 32'h1234_ABCD, 1, 0);  // 22
        // interrupt clear through IM, one edge behind the write
        v(1, 12, 32'hFB02, 0, 6'h00, 32'hDEAD_BEEF, 32'h0000_FF01, 1, 0); // 23
        v(0, 12, 0, 0, 6'h00, 32'hDEAD_BEEF, 32'h0000_FB02, 1, 0);  // 24
        v(0, 13, 0, 0, 6'h00, 32'hDEAD_BEEF, 32'h0000_8000, 1, 0);  // 25
        v(1, 12, 32'h7F02, 0, 6'h00, 32'hDEAD_BEEF, 32'h0000_FB02, 1, 0); // 26
        v(0, 13, 0, 0, 6'h00, 32'hDEAD_BEEF, 32'h0000_8000, 1, 0);  // 27
        v(0, 13, 0, 0, 6'h00, 32'hDEAD_BEEF, 32'h0000_0028, 0, 0);  // 28
        v(0, 14, 0, 0, 6'h00, 32'hDEAD_BEEF, 32'h1234_ABCD, 0, 0);  // 29
        // unmapped address, EPC writable
        v(1, 5, 32'hFFFF_FFFF, 0, 6'h00, 32'hDEAD_BEEF, 32'h0, 0, 0);    // 30
        v(0, 5, 0, 0, 6'h00, 32'hDEAD_BEEF, 32'h0, 0, 0);                // 31
        v(1, 14, 32'hCAFE_F00D, 0, 6'h00, 32'hDEAD_BEEF, 32'h1234_ABCD, 0, 0); // 32
        v(0, 14, 0, 0, 6'h00, 32'hDEAD_BEEF, 32'hCAFE_F00D, 0, 0);  // 33
        // trap set coincides with an IE=1 write: set wins, EPC captured
        v(1, 12, 32'h0001, 1, 6'h00, 32'h400, 32'h0000_7F02, 1, 0); // 34
        v(0, 12, 0, 1, 6'h00, 32'h400, 32'h0000_0003, 1, 0);        // 35
        v(0, 13, 0, 0, 6'h00, 32'h400, 32'h0000_0030, 1, 0);        // 36
        v(0, 14, 0, 0, 6'h00, 32'h400, 32'h0000_0400, 1, 0);        // 37
        v(1, 12, 32'h0001, 0, 6'h00, 32'h400, 32'h0000_0003, 1, 0); // 38
        // EPC capture outranks a CPU write in the same cycle
        v(1, 14, 32'h5555_5555, 1, 6'h00, 32'h800, 32'h0000_0400, 1, 0); // 39
        v(0, 14, 0, 1, 6'h00, 32'h800, 32'h0000_0800, 1, 0);        // 40
        v(0, 13, 0, 1, 6'h00, 32'h800, 32'h0000_0030, 1, 0);        // 41

        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;

        for (int i = 0; i < vq.size(); i++) begin
            @(negedge clk);
            we1 = vq[i].we; addr = vq[i].addr; wd = vq[i].wd;
            alu_trap = vq[i].trap; interrupt = vq[i].intr; pcp4 = vq[i].pcp4;
            #1;
            chk32($sformatf("v%0d rd1", i), rd1, vq[i].exp_rd);
            chk1($sformatf("v%0d exl", i), exl, vq[i].exp_exl);
            chk1($sformatf("v%0d iv", i), iv, vq[i].exp_iv);
        end

        // async reset in the middle of a trap exception
        @(negedge clk);
        we1 = 1'b0; alu_trap = 1'b0; interrupt = '0; addr = 5'd13;
        #1;
        chk1("pre-reset exl", exl, 1'b1);
        rst = 1'b0;
        #1;
        chk32("rst cause", rd1, 32'h0000_0028);
        chk1("rst exl", exl, 1'b0);
        chk1("rst iv", iv, 1'b0);
        addr = 5'd12; #1;
        chk32("rst status", rd1, 32'h0);
        addr = 5'd14; #1;
        chk32("rst epc", rd1, 32'h0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        addr = 5'd13; #1;
        chk32("post-reset cause", rd1, 32'h0000_0028);
        chk1("post-reset exl", exl, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
